// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the core's load/store port and
// a debug/loader master. The core sees a zero-latency path straight through to
// the memory. The debug master uses a req/ack handshake. A pending debug
// request wins on any cycle the core is idle. Under continuous core traffic
// it is forced through after MAX_WAIT denied cycles. On the cycle the debug
// master takes the memory while the core also wants it, the core is stalled.
//
// Parameters
//   MAX_WAIT  : consecutive denied cycles before a debug request preempts the
//               core (0 = debug always wins immediately)
//   CNT_W     : width of the saturating stall performance counter
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   cpu_req/we/adr/wd, cpu_rd     : core data port (cpu_rd is mem_rd)
//   cpu_stall                     : core must hold state this cycle
//   dbg_req/we/adr/wd             : debug request, held until dbg_ack
//   dbg_rd, dbg_ack               : registered read data, one-cycle ack pulse
//   mem_we/adr/wd, mem_rd         : to/from dmem (async read, sync write)
//   stall_cnt                     : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_adr,
    input  logic [31:0]      cpu_wd,
    output logic [31:0]      cpu_rd,
    output logic             cpu_stall,

    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [31:0]      dbg_adr,
    input  logic [31:0]      dbg_wd,
    output logic [31:0]      dbg_rd,
    output logic             dbg_ack,

    output logic             mem_we,
    output logic [31:0]      mem_adr,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd,

    output logic [CNT_W-1:0] stall_cnt
);

    // The wait counter only has to reach MAX_WAIT; keep at least one bit so
    // the MAX_WAIT = 0 configuration still elaborates.
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic [31:0]        dbg_rd_q,    dbg_rd_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               dbg_gnt;
    logic               wait_expired;

    // The counter saturates at WAIT_LIMIT and never goes past it, so an
    // equality test is the same as ">= MAX_WAIT". With MAX_WAIT = 0 the
    // counter is stuck at zero and the test is always true.
    assign wait_expired = (wait_cnt_q == WAIT_LIMIT);

    // Debug grant: never in the ACK cycle, so back-to-back debug transactions
    // always leave a free cycle for the core in between.
    assign dbg_gnt = dbg_req && (state_q != ST_ACK) && (!cpu_req || wait_expired);

    // Memory mux. The core path is purely combinational so a single-cycle
    // datapath sees memory with zero latency. Writes are blocked during reset
    // so a transaction caught by reset cannot corrupt memory.
    always_comb begin
        mem_adr = cpu_adr;
        mem_wd  = cpu_wd;
        mem_we  = cpu_req && cpu_we;
        if (dbg_gnt) begin
            mem_adr = dbg_adr;
            mem_wd  = dbg_wd;
            mem_we  = dbg_we;
        end
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    assign cpu_rd    = mem_rd;
    assign cpu_stall = cpu_req && dbg_gnt;

    // Debug handshake FSM. IDLE and WAIT both accept a grant; WAIT only
    // exists to remember that the request has already been refused, so the
    // wait counter keeps climbing towards the preemption point. Dropping the
    // request while waiting abandons it silently.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dbg_rd_d   = dbg_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (dbg_gnt) begin
                    state_d  = ST_ACK;
                    dbg_rd_d = mem_rd;
                end else if (dbg_req) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end

            ST_WAIT: begin
                if (dbg_gnt) begin
                    state_d    = ST_ACK;
                    dbg_rd_d   = mem_rd;
                    wait_cnt_d = '0;
                end else if (!dbg_req) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (!wait_expired) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Stall performance counter, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cpu_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            dbg_rd_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_rd_q    <= dbg_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dbg_ack   = (state_q == ST_ACK);
    assign dbg_rd    = dbg_rd_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Two arbiters side by side: dut0 with MAX_WAIT = 4 / CNT_W = 16 and dut1
// with MAX_WAIT = 0 / CNT_W = 4, each backed by its own small data memory.
// A transaction-level reference model predicts every output on every cycle,
// and directed sequences pin known literal values before a randomized run.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b1;
    logic rst;

    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_adr   [2];
    logic [31:0] cpu_wd    [2];
    logic [31:0] cpu_rd    [2];
    logic        cpu_stall [2];
    logic        dbg_req   [2];
    logic        dbg_we    [2];
    logic [31:0] dbg_adr   [2];
    logic [31:0] dbg_wd    [2];
    logic [31:0] dbg_rd    [2];
    logic        dbg_ack   [2];
    logic        mem_we    [2];
    logic [31:0] mem_adr   [2];
    logic [31:0] mem_wd    [2];
    logic [31:0] mem_rd    [2];
    logic [15:0] stall0;
    logic [3:0]  stall1;
    logic [31:0] stall_w   [2];

    logic [31:0] dmem [2][64];
    bit          dmem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_adr(cpu_adr[0]), .cpu_wd(cpu_wd[0]),
        .cpu_rd(cpu_rd[0]), .cpu_stall(cpu_stall[0]),
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_adr(dbg_adr[0]), .dbg_wd(dbg_wd[0]),
        .dbg_rd(dbg_rd[0]), .dbg_ack(dbg_ack[0]),
        .mem_we(mem_we[0]), .mem_adr(mem_adr[0]), .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0]),
        .stall_cnt(stall0)
    );

    dmem_arbiter #(.MAX_WAIT(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_adr(cpu_adr[1]), .cpu_wd(cpu_wd[1]),
        .cpu_rd(cpu_rd[1]), .cpu_stall(cpu_stall[1]),
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_adr(dbg_adr[1]), .dbg_wd(dbg_wd[1]),
        .dbg_rd(dbg_rd[1]), .dbg_ack(dbg_ack[1]),
        .mem_we(mem_we[1]), .mem_adr(mem_adr[1]), .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1]),
        .stall_cnt(stall1)
    );

    assign stall_w[0] = {16'b0, stall0};
    assign stall_w[1] = {28'b0, stall1};

    // Data memories: asynchronous read, synchronous write, cleared once.
    assign mem_rd[0] = dmem[0][mem_adr[0][7:2]];
    assign mem_rd[1] = dmem[1][mem_adr[1][7:2]];

    always @(posedge clk) begin
        if (!dmem_ready) begin
            for (int i = 0; i < 2; i++)
                for (int w = 0; w < 64; w++)
                    dmem[i][w] <= 32'h0;
            dmem_ready <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++)
                if (mem_we[i] === 1'b1)
                    dmem[i][mem_adr[i][7:2]] <= mem_wd[i];
        end
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL dut%0d %s: actual %h required %h", inst, name, actual, expected);
        end
    endtask

    function automatic int maxWaitOf(input int inst);
        return (inst == 0) ? 4 : 0;
    endfunction

    function automatic int stallMaxOf(input int inst);
        return (inst == 0) ? 65535 : 15;
    endfunction

    // Reference model: tracks whether an ack is owed next cycle, how many
    // consecutive cycles the current debug request has been refused, the last
    // debug read word, the stall count and a private copy of memory.
    bit          m_init [2];
    bit          m_ack  [2];
    int          m_denied [2];
    logic [31:0] m_rd   [2];
    int          m_stall [2];
    logic [31:0] m_mem  [2][64];
    bit          m_mem_ready = 1'b0;

    logic        e_gnt, e_we, e_stall;
    logic [31:0] e_adr, e_wd, e_rd;

    always @(negedge clk) begin
        if (!m_mem_ready) begin
            for (int i = 0; i < 2; i++) begin
                m_init[i] = 1'b0;
                for (int w = 0; w < 64; w++)
                    m_mem[i][w] = 32'h0;
            end
            m_mem_ready = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            e_gnt   = dbg_req[i] && !m_ack[i] && (!cpu_req[i] || m_denied[i] >= maxWaitOf(i));
            e_adr   = e_gnt ? dbg_adr[i] : cpu_adr[i];
            e_wd    = e_gnt ? dbg_wd[i] : cpu_wd[i];
            e_we    = !rst && (e_gnt ? dbg_we[i] : (cpu_req[i] && cpu_we[i]));
            e_stall = cpu_req[i] && e_gnt;
            e_rd    = m_mem[i][e_adr[7:2]];
            if (m_init[i]) begin
                checkOutput("mem_adr",   i, mem_adr[i],           e_adr);
                checkOutput("mem_wd",    i, mem_wd[i],            e_wd);
                checkOutput("mem_we",    i, 32'(mem_we[i]),       32'(e_we));
                checkOutput("cpu_stall", i, 32'(cpu_stall[i]),    32'(e_stall));
                checkOutput("cpu_rd",    i, cpu_rd[i],            e_rd);
                checkOutput("dbg_ack",   i, 32'(dbg_ack[i]),      32'(m_ack[i]));
                checkOutput("dbg_rd",    i, dbg_rd[i],            m_rd[i]);
                checkOutput("stall_cnt", i, stall_w[i],           32'(m_stall[i]));
            end
            if (rst) begin
                m_init[i]   = 1'b1;
                m_ack[i]    = 1'b0;
                m_denied[i] = 0;
                m_rd[i]     = 32'h0;
                m_stall[i]  = 0;
            end else begin
                if (e_we) m_mem[i][e_adr[7:2]] = e_wd;
                if (e_gnt) m_rd[i] = e_rd;
                if (dbg_req[i] && !m_ack[i] && !e_gnt)
                    m_denied[i] = (m_denied[i] + 1 > maxWaitOf(i)) ? maxWaitOf(i) : m_denied[i] + 1;
                else
                    m_denied[i] = 0;
                m_ack[i] = e_gnt;
                if (e_stall && m_stall[i] < stallMaxOf(i)) m_stall[i]++;
            end
        end
    end

    task automatic applyStimulus(input int inst,
                                 input logic creq, input logic cwe,
                                 input logic [31:0] cadr, input logic [31:0] cwd,
                                 input logic dreq, input logic dwe,
                                 input logic [31:0] dadr, input logic [31:0] dwd);
        cpu_req[inst] = creq;
        cpu_we[inst]  = cwe;
        cpu_adr[inst] = cadr;
        cpu_wd[inst]  = cwd;
        dbg_req[inst] = dreq;
        dbg_we[inst]  = dwe;
        dbg_adr[inst] = dadr;
        dbg_wd[inst]  = dwd;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randAdr();
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        return {26'b0, w, 2'b00};
    endfunction

    bit outstanding [2];

    initial begin
        // Reset with a core store pending: the store must not reach memory.
        rst = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 32'h10, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        midCycle();
        checkOutput("rst_mem_we", 0, 32'(mem_we[0]), 32'h0);
        nextCycle();
        midCycle();
        checkOutput("rst_mem_we2", 0, 32'(mem_we[0]), 32'h0);
        checkOutput("rst_dbg_ack", 0, 32'(dbg_ack[0]), 32'h0);
        checkOutput("rst_dbg_rd", 0, dbg_rd[0], 32'h0);
        checkOutput("rst_stall_cnt", 0, stall_w[0], 32'h0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        midCycle();
        checkOutput("post_rst_dbg_ack", 0, 32'(dbg_ack[0]), 32'h0);
        checkOutput("post_rst_dbg_rd", 0, dbg_rd[0], 32'h0);
        checkOutput("post_rst_stall", 1, stall_w[1], 32'h0);
        nextCycle();

        // Idle core: debug write then debug read, each acked one cycle later.
        applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        midCycle();
        checkOutput("wr_mem_we", 0, 32'(mem_we[0]), 32'h1);
        checkOutput("wr_mem_adr", 0, mem_adr[0], 32'h40);
        checkOutput("wr_cpu_stall", 0, 32'(cpu_stall[0]), 32'h0);
        checkOutput("wr_no_ack_yet", 0, 32'(dbg_ack[0]), 32'h0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0);
        midCycle();
        checkOutput("wr_ack", 0, 32'(dbg_ack[0]), 32'h1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        midCycle();
        checkOutput("rd_no_ack_yet", 0, 32'(dbg_ack[0]), 32'h0);
        checkOutput("rd_cpu_stall", 0, 32'(cpu_stall[0]), 32'h0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0);
        midCycle();
        checkOutput("rd_ack", 0, 32'(dbg_ack[0]), 32'h1);
        checkOutput("rd_data", 0, dbg_rd[0], 32'hDEADBEEF);
        nextCycle();

        // Continuous core traffic: four refusals, forced grant, ack after.
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int c = 0; c < 4; c++) begin
            midCycle();
            checkOutput("wc_cpu_owns_stall", 0, 32'(cpu_stall[0]), 32'h0);
            checkOutput("wc_cpu_owns_adr", 0, mem_adr[0], 32'h20);
            nextCycle();
        end
        midCycle();
        checkOutput("wc_preempt_stall", 0, 32'(cpu_stall[0]), 32'h1);
        checkOutput("wc_preempt_adr", 0, mem_adr[0], 32'h40);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        midCycle();
        checkOutput("wc_ack", 0, 32'(dbg_ack[0]), 32'h1);
        checkOutput("wc_rd", 0, dbg_rd[0], 32'hDEADBEEF);
        checkOutput("wc_stall_cnt", 0, stall_w[0], 32'h1);
        checkOutput("wc_ack_no_stall", 0, 32'(cpu_stall[0]), 32'h0);
        nextCycle();

        // Request held through ACK with an idle core: grant/ack alternate.
        applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 0; k < 6; k++) begin
            midCycle();
            checkOutput("hold_ack", 0, 32'(dbg_ack[0]), (k % 2 == 1) ? 32'h1 : 32'h0);
            checkOutput("hold_adr", 0, mem_adr[0], (k % 2 == 1) ? 32'h20 : 32'h40);
            nextCycle();
        end

        // Abandon after two refusals, then a fresh request waits the full four.
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int c = 0; c < 2; c++) begin
            midCycle();
            checkOutput("abandon_denied", 0, 32'(cpu_stall[0]), 32'h0);
            nextCycle();
        end
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0);
        midCycle();
        checkOutput("abandon_no_ack", 0, 32'(dbg_ack[0]), 32'h0);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int c = 0; c < 4; c++) begin
            midCycle();
            checkOutput("rewait_denied", 0, 32'(cpu_stall[0]), 32'h0);
            checkOutput("rewait_no_ack", 0, 32'(dbg_ack[0]), 32'h0);
            nextCycle();
        end
        midCycle();
        checkOutput("rewait_preempt", 0, 32'(cpu_stall[0]), 32'h1);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        midCycle();
        checkOutput("rewait_ack", 0, 32'(dbg_ack[0]), 32'h1);
        checkOutput("rewait_stall_cnt", 0, stall_w[0], 32'h2);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // MAX_WAIT = 0: debug wins at once; the core store retried next commits.
        applyStimulus(1, 1'b1, 1'b1, 32'h10, 32'h11111111, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
        midCycle();
        checkOutput("mw0_stall", 1, 32'(cpu_stall[1]), 32'h1);
        checkOutput("mw0_adr", 1, mem_adr[1], 32'h30);
        checkOutput("mw0_we", 1, 32'(mem_we[1]), 32'h1);
        nextCycle();
        applyStimulus(1, 1'b1, 1'b1, 32'h10, 32'h11111111, 1'b0, 1'b0, 32'h30, 32'h0);
        midCycle();
        checkOutput("mw0_no_stall", 1, 32'(cpu_stall[1]), 32'h0);
        checkOutput("mw0_ack", 1, 32'(dbg_ack[1]), 32'h1);
        checkOutput("mw0_cpu_adr", 1, mem_adr[1], 32'h10);
        checkOutput("mw0_stall_cnt", 1, stall_w[1], 32'h1);
        nextCycle();
        applyStimulus(1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        midCycle();
        checkOutput("mw0_dbg_wr_seen", 1, cpu_rd[1], 32'hA5A5A5A5);
        nextCycle();
        applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        midCycle();
        checkOutput("mw0_cpu_wr_seen", 1, cpu_rd[1], 32'h11111111);
        nextCycle();

        // Twenty more stalls on a 4-bit counter: it must stick at 15.
        applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
        for (int k = 0; k < 40; k++) begin
            midCycle();
            checkOutput("sat_alt_stall", 1, 32'(cpu_stall[1]), (k % 2 == 0) ? 32'h1 : 32'h0);
            nextCycle();
        end
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        midCycle();
        checkOutput("sat_stall_cnt", 1, stall_w[1], 32'hF);
        nextCycle();

        // Randomized traffic with legal debug handshakes and rare resets.
        outstanding[0] = 1'b0;
        outstanding[1] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    outstanding[i] = 1'b0;
                    dbg_req[i] = 1'b0;
                end else if (dbg_ack[i]) begin
                    outstanding[i] = 1'b0;
                    dbg_req[i] = ($urandom_range(0, 1) == 1);
                end else if (outstanding[i]) begin
                    if ($urandom_range(0, 19) == 0) begin
                        dbg_req[i] = 1'b0;
                        outstanding[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    dbg_req[i] = 1'b1;
                    dbg_we[i]  = ($urandom_range(0, 1) == 1);
                    dbg_adr[i] = randAdr();
                    dbg_wd[i]  = $urandom();
                    outstanding[i] = 1'b1;
                end else begin
                    dbg_req[i] = 1'b0;
                end
                cpu_req[i] = ($urandom_range(0, 9) < 7);
                cpu_we[i]  = ($urandom_range(0, 9) < 3);
                cpu_adr[i] = randAdr();
                cpu_wd[i]  = $urandom();
            end
            nextCycle();
        end

        rst = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
